adc_scan_sequencer: RTL
=======================

# adc_scan_sequencer

Round-robin scan controller that sits between the ADC conversion front end and the HPS-visible ADC PIO exports. It sequences conversions over the enabled channels and averages a fixed number of samples per channel. It publishes one zero-extended result per channel into a register bank that drives `adc_channel_0..7_export`. It also derives the threshold LED word for `adc_leds_export`.

## Interface
- `NUM_CH`, 8: channel count; must be a power of two, 2 to 8.
- `SAMPLE_W`, 12: conversion data width.
- `OUT_W`, 64: per-channel export width; requires OUT_W ≥ SAMPLE_W.
- `AVG_LOG2`, 2: log2 of the samples averaged per channel.
- `TIMEOUT`, 1023: maximum WAIT cycles before a conversion is abandoned.

Ports, clock and reset first:
- `clk_clk` in 1: single clock; all logic synchronous to its rising edge.
- `reset_reset` in 1: asynchronous, active-high reset.
- `enable` in 1: level; scanning runs while high.
- `ch_mask` in NUM_CH: bit i=1 includes channel i in the scan.
- `threshold` in SAMPLE_W: LED compare level.
- `conv_start` out 1: one-cycle conversion request.
- `conv_ch` out log2(NUM_CH): channel under conversion; stable from START until the conversion ends.
- `conv_valid` in 1: one-cycle strobe qualifying `conv_data`.
- `conv_data` in SAMPLE_W: conversion result.
- `ch_result` out NUM_CH*OUT_W: result bank, channel i at [i*OUT_W +: OUT_W].
- `ch_error` out NUM_CH: sticky timeout flag per channel.
- `leds` out OUT_W: bit i = (result_i ≥ threshold); bits ≥ NUM_CH are 0.
- `scan_done` out 1: one-cycle pulse at the end of each full pass.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, START, WAIT, ACCUM, STORE, NEXT.
- IDLE → START when `enable`=1 and `ch_mask`≠0; `conv_ch` = lowest set mask bit.
- START: `conv_start`=1 for exactly one cycle, then → WAIT. The timeout counter clears.
- WAIT:
  - `conv_valid` → ACCUM.
  - Counter reaching TIMEOUT → set `ch_error[conv_ch]`, discard the partial sum, → NEXT. The stored result is left unchanged.
  - `conv_valid` arriving in START, or in any state other than WAIT, is ignored.
- ACCUM: sum += conv_data; sample count +1. Count = 2^AVG_LOG2 → STORE, else → START.
- Accumulator is SAMPLE_W+AVG_LOG2 bits wide and cannot overflow.
- STORE: result[conv_ch] = sum >> AVG_LOG2 (truncating), zero-extended to OUT_W. Clear sum and count; clear `ch_error[conv_ch]`; → NEXT.
- NEXT: search for the next set mask bit above `conv_ch`.
  - If found, load it into `conv_ch` and → START.
  - If none is found (wrap-around), pulse `scan_done`. Then → START at the lowest set bit if `enable`=1 and mask≠0, else → IDLE.
- `ch_mask` is sampled only in IDLE and NEXT. A mid-conversion change completes the current channel first.
- `enable` deasserted mid-scan: the current channel completes through STORE or timeout, then → IDLE without `scan_done`. The result bank is kept.
- `leds` is registered and updated every cycle from the result bank and `threshold`.

## Timing
- Reset: state IDLE; `conv_start`, `scan_done`, `busy`=0; `conv_ch`=0; `ch_result`, `ch_error`, `leds`=0; sum and count 0.
- Reset asserted mid-operation aborts immediately to the reset values.
- Minimum cycles per sample = 3 + ADC latency (START, WAIT ≥1, ACCUM).
- The result is visible on `ch_result` the cycle after STORE.
- `leds` lags `ch_result` by 1 cycle.
- `scan_done` is asserted in the cycle after the final NEXT evaluation.
- Single enabled channel: NEXT wraps to the same channel and pulses `scan_done` each pass.

## Configuration
- `ADC_SCAN_AVG_EN` defined: averaging as above.
- `ADC_SCAN_AVG_EN` undefined: AVG_LOG2 is forced to 0, the accumulator and count logic are removed, and ACCUM goes straight to STORE. Each channel then stores a single raw sample.

## Structure
- Package `adc_scan_pkg`: FSM state enum and `ch_idx_t` typedef (log2(NUM_CH) bits).
- Sub-module `adc_scan_next_ch`: combinational priority search returning the next set mask bit above a given index, plus a wrap flag and the lowest set bit.

## Test plan
- Mask 8'hFF, ADC model returns 100+ch with 5-cycle latency, AVG_LOG2=2 → results 100..107, `scan_done` once per pass, `leds`=8'hF0 with threshold=104.
- Mask 8'b0010_0100, samples 10,11,12,13 on ch2 → result[2]=11; only channels 2 and 5 are converted, and `conv_ch` never shows another value.
- ch3 never returns `conv_valid` → `ch_error[3]`=1 after TIMEOUT cycles, result[3] unchanged, scan continues to ch4. The flag clears on the next good ch3 conversion.
- `enable` dropped during a ch1 conversion → ch1 result stored, FSM reaches IDLE, no `scan_done`, `busy`=0.
- Reset asserted in WAIT → all outputs return to 0 in the same cycle; after release, the scan restarts from the lowest mask bit.
- Build without `ADC_SCAN_AVG_EN`, sample 4095 on ch0 → result[0]=4095 after a single conversion.

Source files
------------

// File: rtl/adc_scan_pkg.sv
// Shared types for the ADC scan sequencer: FSM state encoding and channel index.
// Channel indices are sized for the largest supported scan (8 channels).
package adc_scan_pkg;

  localparam int unsigned MAX_CH   = 8;
  localparam int unsigned CH_IDX_W = $clog2(MAX_CH);

  typedef logic [CH_IDX_W-1:0] ch_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ACCUM = 3'd3,
    ST_STORE = 3'd4,
    ST_NEXT  = 3'd5
  } adc_state_e;

endpackage

// File: rtl/adc_scan_next_ch.sv
// Priority search over the channel mask: next set bit strictly above cur_i,
// wrap flag when none exists, and the lowest set bit for restarting a pass.
module adc_scan_next_ch
  import adc_scan_pkg::*;
#(
  parameter int unsigned NUM_CH = 8
) (
  input  logic [NUM_CH-1:0] mask_i,
  input  ch_idx_t           cur_i,
  output ch_idx_t           next_o,
  output logic              wrap_o,
  output ch_idx_t           lowest_o
);

  // Scanning downward lets the last hit win, which is the lowest qualifying bit.
  always_comb begin
    next_o   = '0;
    wrap_o   = 1'b1;
    lowest_o = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        lowest_o = ch_idx_t'(i);
        if (i > int'(cur_i)) begin
          next_o = ch_idx_t'(i);
          wrap_o = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Round-robin ADC scan controller with per-channel averaging and a result bank.
// Averaging is built only when ADC_SCAN_AVG_EN is defined; otherwise one raw sample per channel.
module adc_scan_sequencer
  import adc_scan_pkg::*;
#(
  parameter int unsigned NUM_CH   = 8,
  parameter int unsigned SAMPLE_W = 12,
  parameter int unsigned OUT_W    = 64,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset,
  input  logic                      enable,
  input  logic [NUM_CH-1:0]         ch_mask,
  input  logic [SAMPLE_W-1:0]       threshold,
  output logic                      conv_start,
  output logic [$clog2(NUM_CH)-1:0] conv_ch,
  input  logic                      conv_valid,
  input  logic [SAMPLE_W-1:0]       conv_data,
  output logic [NUM_CH*OUT_W-1:0]   ch_result,
  output logic [NUM_CH-1:0]         ch_error,
  output logic [OUT_W-1:0]          leds,
  output logic                      scan_done,
  output logic                      busy,
  output adc_state_e                dbg_state_o
);

  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
`ifdef ADC_SCAN_AVG_EN
  localparam int unsigned AVG_EFF = AVG_LOG2;
`else
  // Raw-sample build: the averaging depth collapses to a single sample.
  localparam int unsigned AVG_EFF = 0 * AVG_LOG2;
`endif
  localparam int unsigned ACC_W = SAMPLE_W + AVG_EFF;
  localparam int unsigned CNT_W = AVG_EFF + 1;

  // Handshake: conv_start is a one-cycle request with conv_ch held stable until
  // the conversion ends; conv_valid is a one-cycle strobe qualifying conv_data and
  // is honoured only in WAIT, so strobes in any other state are dropped.

  adc_state_e                          state_q;
  ch_idx_t                             ch_q;
  logic [TMO_W-1:0]                    tmo_q;
  logic [SAMPLE_W-1:0]                 sample_q;
  logic [NUM_CH-1:0][SAMPLE_W-1:0]     result_q;
  logic [NUM_CH-1:0]                   err_q;
  logic [NUM_CH-1:0]                   leds_q;
  logic                                start_q;
  logic                                done_q;
  logic                                busy_q;

`ifdef ADC_SCAN_AVG_EN
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sum_d = sum_q + ACC_W'(sample_q);
    cnt_d = cnt_q + 1'b1;
  end
`endif

  ch_idx_t next_ch, lowest_ch;
  logic    wrap;
  logic    mask_any;

  assign mask_any = |ch_mask;

  adc_scan_next_ch #(
    .NUM_CH (NUM_CH)
  ) u_next_ch (
    .mask_i   (ch_mask),
    .cur_i    (ch_q),
    .next_o   (next_ch),
    .wrap_o   (wrap),
    .lowest_o (lowest_ch)
  );

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q  <= ST_IDLE;
      ch_q     <= '0;
      tmo_q    <= '0;
      sample_q <= '0;
      result_q <= '0;
      err_q    <= '0;
      leds_q   <= '0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef ADC_SCAN_AVG_EN
      sum_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        leds_q[i] <= (result_q[i] >= threshold);
      end

      case (state_q)
        ST_IDLE: begin
          if (enable && mask_any) begin
            ch_q    <= lowest_ch;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_START;
          end
        end

        ST_START: begin
          tmo_q   <= '0;
          state_q <= ST_WAIT;
        end

        ST_WAIT: begin
          if (conv_valid) begin
            sample_q <= conv_data;
            state_q  <= ST_ACCUM;
          end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            // Abandon the channel: flag it, drop partial samples, keep the old result.
            err_q[ch_q[CH_W-1:0]] <= 1'b1;
`ifdef ADC_SCAN_AVG_EN
            sum_q <= '0;
            cnt_q <= '0;
`endif
            state_q <= ST_NEXT;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        ST_ACCUM: begin
`ifdef ADC_SCAN_AVG_EN
          sum_q <= sum_d;
          cnt_q <= cnt_d;
          if (cnt_d == CNT_W'(2 ** AVG_EFF)) begin
            state_q <= ST_STORE;
          end else begin
            start_q <= 1'b1;
            state_q <= ST_START;
          end
`else
          state_q <= ST_STORE;
`endif
        end

        ST_STORE: begin
`ifdef ADC_SCAN_AVG_EN
          result_q[ch_q[CH_W-1:0]] <= SAMPLE_W'(sum_q >> AVG_EFF);
          sum_q <= '0;
          cnt_q <= '0;
`else
          result_q[ch_q[CH_W-1:0]] <= sample_q >> AVG_EFF;
`endif
          err_q[ch_q[CH_W-1:0]] <= 1'b0;
          state_q <= ST_NEXT;
        end

        ST_NEXT: begin
          if (!enable) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (!wrap) begin
            ch_q    <= next_ch;
            start_q <= 1'b1;
            state_q <= ST_START;
          end else begin
            done_q <= 1'b1;
            if (mask_any) begin
              ch_q    <= lowest_ch;
              start_q <= 1'b1;
              state_q <= ST_START;
            end else begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_bank
    assign ch_result[g*OUT_W +: OUT_W] = OUT_W'(result_q[g]);
  end

  assign conv_start  = start_q;
  assign conv_ch     = ch_q[CH_W-1:0];
  assign ch_error    = err_q;
  assign leds        = OUT_W'(leds_q);
  assign scan_done   = done_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule
